seg_scan_ctrl: RTL and testbench

//   Parametrised multiplexed seven-segment scan controller, successor to the fixed 16-digit hex scanner.

---
 rtl/seg_scan_ctrl_pkg.sv | 30 +++
 rtl/seg_hex_decode.sv | 32 +++
 rtl/seg_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: glyph codes and scan FSM states.
// Glyph constants are active-low {dp,g,f,e,d,c,b,a} with the decimal point off.
package seg_scan_ctrl_pkg;

    localparam logic [7:0] SEG_OFF  = 8'hff;

    localparam logic [7:0] SEG_NUM0 = 8'hc0;
    localparam logic [7:0] SEG_NUM1 = 8'hf9;
    localparam logic [7:0] SEG_NUM2 = 8'ha4;
    localparam logic [7:0] SEG_NUM3 = 8'hb0;
    localparam logic [7:0] SEG_NUM4 = 8'h99;
    localparam logic [7:0] SEG_NUM5 = 8'h92;
    localparam logic [7:0] SEG_NUM6 = 8'h82;
    localparam logic [7:0] SEG_NUM7 = 8'hf8;
    localparam logic [7:0] SEG_NUM8 = 8'h80;
    localparam logic [7:0] SEG_NUM9 = 8'h90;
    localparam logic [7:0] SEG_NUMA = 8'h88;
    localparam logic [7:0] SEG_NUMB = 8'h83;
    localparam logic [7:0] SEG_NUMC = 8'hc6;
    localparam logic [7:0] SEG_NUMD = 8'ha1;
    localparam logic [7:0] SEG_NUME = 8'h86;
    localparam logic [7:0] SEG_NUMF = 8'h8e;

    // DEAD: all selects off at slot start; ON: digit may be driven, gated by PWM.
    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_ON   = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-low seven-segment glyph {g,f,e,d,c,b,a}; purely combinational.
module seg_hex_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_OFF[6:0];
        case (nibble)
            4'h0: glyph = SEG_NUM0[6:0];
            4'h1: glyph = SEG_NUM1[6:0];
            4'h2: glyph = SEG_NUM2[6:0];
            4'h3: glyph = SEG_NUM3[6:0];
            4'h4: glyph = SEG_NUM4[6:0];
            4'h5: glyph = SEG_NUM5[6:0];
            4'h6: glyph = SEG_NUM6[6:0];
            4'h7: glyph = SEG_NUM7[6:0];
            4'h8: glyph = SEG_NUM8[6:0];
            4'h9: glyph = SEG_NUM9[6:0];
            4'ha: glyph = SEG_NUMA[6:0];
            4'hb: glyph = SEG_NUMB[6:0];
            4'hc: glyph = SEG_NUMC[6:0];
            4'hd: glyph = SEG_NUMD[6:0];
            4'he: glyph = SEG_NUME[6:0];
            4'hf: glyph = SEG_NUMF[6:0];
            default: glyph = SEG_OFF[6:0];
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with dead time, PWM brightness, blanking, leading-zero
// suppression and a double-buffered frame write port that swaps only at frame boundaries.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int DIGITS      = 16,
    parameter int CLK_DIV     = 10000,
    parameter int DEAD_CYC    = 16,
    parameter int BRIGHT_W    = 4,
    parameter int SEL_ACT_LOW = 1,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     wr_dp,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  lz_en,
    input  logic [BRIGHT_W-1:0]   bright,
    input  logic                  disp_en,
    output logic                  frame_done,
    output logic [DIGITS-1:0]     dig_sel,
    output logic [7:0]            seg
);

    localparam int SLOT_W = $clog2(CLK_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] DEAD_END  = SLOT_W'(DEAD_CYC);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_OFF   = (SEL_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]        SEG_DARK  = (SEG_ACT_LOW != 0) ? SEG_OFF : ~SEG_OFF;

    // Handshake: a write is accepted on any cycle with wr_valid & wr_ready; wr_ready is the
    // registered complement of pending, so at most one frame waits in the shadow buffer.
    scan_state_t           state;
    logic [SLOT_W-1:0]     slot_cnt, slot_nxt;
    logic [IDX_W-1:0]      dig_idx, dig_nxt;
    logic [BRIGHT_W-1:0]   pwm_cnt;
    logic [4*DIGITS-1:0]   act_data, shd_data;
    logic [DIGITS-1:0]     act_dp, shd_dp;
    logic                  pending;
    logic [DIGITS-1:0]     dark;
    logic                  zero_run;
    logic [3:0]            cur_nib;
    logic                  cur_dp, cur_dark, lit;
    logic [6:0]            cur_glyph;
    logic [7:0]            seg_lo;
    logic [DIGITS-1:0]     sel_hot;

    assign wr_ready = ~pending;

    always_comb begin
        slot_nxt = (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 1'b1;
        dig_nxt  = dig_idx;
        if (slot_cnt == SLOT_LAST)
            dig_nxt = (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
    end

    // Leading-zero chain walks from the most significant digit down; digit 0 always shows.
    always_comb begin
        zero_run = 1'b1;
        dark     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (act_data[4*i +: 4] == 4'h0);
            dark[i]  = ~disp_en | blank_mask[i] | (lz_en & zero_run & (i != 0));
        end
    end

    always_comb begin
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_dark = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_idx == IDX_W'(i)) begin
                cur_nib  = act_data[4*i +: 4];
                cur_dp   = act_dp[i];
                cur_dark = dark[i];
            end
        end
    end

    seg_hex_decode u_dec (
        .nibble (cur_nib),
        .glyph  (cur_glyph)
    );

    always_comb begin
        seg_lo  = {~cur_dp, cur_glyph};
        sel_hot = DIGITS'(1) << dig_idx;
        lit     = (state == ST_ON) && (pwm_cnt <= bright) && !cur_dark;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_DEAD;
            slot_cnt   <= '0;
            dig_idx    <= '0;
            pwm_cnt    <= '0;
            frame_done <= 1'b0;
            dig_sel    <= SEL_OFF;
            seg        <= SEG_DARK;
            pending    <= 1'b0;
            act_data   <= '0;
            act_dp     <= '0;
            shd_data   <= '0;
            shd_dp     <= '0;
        end else begin
            slot_cnt   <= slot_nxt;
            dig_idx    <= dig_nxt;
            state      <= (slot_nxt < DEAD_END) ? ST_DEAD : ST_ON;
            pwm_cnt    <= (slot_nxt == DEAD_END) ? '0 : pwm_cnt + 1'b1;
            frame_done <= (slot_nxt == SLOT_LAST) && (dig_nxt == IDX_LAST);

            // seg only moves with dig_idx, which changes while selects are off in DEAD.
            dig_sel <= lit ? ((SEL_ACT_LOW != 0) ? ~sel_hot : sel_hot) : SEL_OFF;
            seg     <= cur_dark ? SEG_DARK : ((SEG_ACT_LOW != 0) ? seg_lo : ~seg_lo);

            // frame_done marks the last cycle of the frame, so the swap lands on digit 0.
            if (wr_valid && !pending) begin
                shd_data <= wr_data;
                shd_dp   <= wr_dp;
                pending  <= 1'b1;
            end else if (frame_done && pending) begin
                act_data <= shd_data;
                act_dp   <= shd_dp;
                pending  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at DIGITS=4, CLK_DIV=8, DEAD_CYC=2, BRIGHT_W=2, active-low pins.
module tb_seg_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int CLK_DIV  = 8;
    localparam int DEAD_CYC = 2;
    localparam int BRIGHT_W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_data = '0;
    logic [3:0]  wr_dp = '0;
    logic [3:0]  blank_mask = '0;
    logic        lz_en = 1'b0;
    logic [1:0]  bright = 2'd3;
    logic        disp_en = 1'b1;
    logic        frame_done;
    logic [3:0]  dig_sel;
    logic [7:0]  seg;

    int errors = 0;
    int checks = 0;

    logic [3:0] sel_log [32];
    logic [7:0] seg_log [32];

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz;
        logic        en;
        logic [1:0]  br;
        logic [31:0] seg_exp;   // {d3,d2,d1,d0} glyph bytes
        logic [11:0] cnt_exp;   // {d3,d2,d1,d0} lit cycles per slot
    } vec_t;

    vec_t vecs [7];
    vec_t post_rst;

    seg_scan_ctrl #(
        .DIGITS      (DIGITS),
        .CLK_DIV     (CLK_DIV),
        .DEAD_CYC    (DEAD_CYC),
        .BRIGHT_W    (BRIGHT_W),
        .SEL_ACT_LOW (1),
        .SEG_ACT_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .blank_mask (blank_mask),
        .lz_en      (lz_en),
        .bright     (bright),
        .disp_en    (disp_en),
        .frame_done (frame_done),
        .dig_sel    (dig_sel),
        .seg        (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Counts negedges until frame_done is seen high; leaves the bench on that negedge.
    task automatic wait_frame(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!frame_done && cycles < 100);
        if (!frame_done) begin
            checks++;
            errors++;
            $display("FAIL frame_done_timeout: no pulse within %0d cycles", cycles);
        end
    endtask

    task automatic write_frame(input logic [15:0] d, input logic [3:0] dp);
        int n;
        wr_data  = d;
        wr_dp    = dp;
        wr_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!wr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) begin
            checks++;
            errors++;
            $display("FAIL write_timeout: wr_ready stayed %0b", wr_ready);
        end
        @(posedge clk);
        #1 wr_valid = 1'b0;
    endtask

    // Called on a frame_done negedge; log[n] holds outputs produced from frame cycle n.
    task automatic capture;
        @(negedge clk);
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            sel_log[n] = dig_sel;
            seg_log[n] = seg;
        end
    endtask

    task automatic check_digits(input vec_t v, input string tag);
        int ns;
        int nh;
        logic [3:0] hot;
        for (int d = 0; d < 4; d++) begin
            hot = ~(4'b0001 << d);
            ns = 0;
            nh = 0;
            for (int s = 0; s < 8; s++) begin
                if (sel_log[8*d+s] != 4'hf) ns++;
                if (sel_log[8*d+s] == hot) nh++;
            end
            check($sformatf("%s_d%0d_sel_cycles", tag, d), ns, 32'(v.cnt_exp[3*d +: 3]));
            check($sformatf("%s_d%0d_onehot", tag, d), nh, 32'(v.cnt_exp[3*d +: 3]));
            check($sformatf("%s_d%0d_seg", tag, d), 32'(seg_log[8*d+7]), 32'(v.seg_exp[8*d +: 8]));
        end
    endtask

    initial begin
        int c;
        logic prev_fd;
        int n;

        vecs[0] = '{16'h1234, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd3,
                    {8'hf9, 8'ha4, 8'h30, 8'h99}, {3'd6, 3'd6, 3'd6, 3'd6}};
        vecs[1] = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd3,
                    {8'hff, 8'hff, 8'h92, 8'hc0}, {3'd0, 3'd0, 3'd6, 3'd6}};
        vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd3,
                    {8'hff, 8'hff, 8'hff, 8'hc0}, {3'd0, 3'd0, 3'd0, 3'd6}};
        vecs[3] = '{16'habcd, 4'b1001, 4'b0100, 1'b0, 1'b1, 2'd0,
                    {8'h08, 8'hff, 8'hc6, 8'h21}, {3'd2, 3'd0, 3'd2, 3'd2}};
        vecs[4] = '{16'h89ef, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3,
                    {8'hff, 8'hff, 8'hff, 8'hff}, {3'd0, 3'd0, 3'd0, 3'd0}};
        vecs[5] = '{16'h0f00, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd1,
                    {8'hff, 8'h0e, 8'hc0, 8'hc0}, {3'd0, 3'd4, 3'd4, 3'd4}};
        vecs[6] = '{16'h5678, 4'b1111, 4'b0000, 1'b0, 1'b1, 2'd2,
                    {8'h12, 8'h02, 8'h78, 8'h00}, {3'd5, 3'd5, 3'd5, 3'd5}};
        post_rst = '{16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3,
                    {8'hc0, 8'hc0, 8'hc0, 8'hc0}, {3'd6, 3'd6, 3'd6, 3'd6}};

        // Reset state and idle frame period
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dig_sel", 32'(dig_sel), 32'h0f);
        check("rst_seg", 32'(seg), 32'hff);
        check("rst_wr_ready", 32'(wr_ready), 32'h1);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        rst = 1'b0;
        wait_frame(c);
        check("first_frame_period", c, 31);
        wait_frame(c);
        check("frame_period", c, 32);

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            lz_en      = vecs[i].lz;
            disp_en    = vecs[i].en;
            bright     = vecs[i].br;
            blank_mask = vecs[i].blank;
            write_frame(vecs[i].data, vecs[i].dp);
            wait_frame(c);
            capture();
            check_digits(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back writes: second is held until the boundary that applies the first
        lz_en = 1'b0; disp_en = 1'b1; bright = 2'd3; blank_mask = 4'b0000;
        write_frame(16'h1111, 4'b0000);
        wr_data  = 16'h2222;
        wr_valid = 1'b1;
        @(negedge clk);
        check("b2b_held_ready", 32'(wr_ready), 32'h0);
        prev_fd = 1'b0;
        n = 0;
        while (!wr_ready && n < 100) begin
            prev_fd = frame_done;
            @(negedge clk);
            n++;
        end
        check("b2b_release_at_boundary", 32'(prev_fd), 32'h1);
        @(posedge clk);
        #1 wr_valid = 1'b0;
        for (int j = 2; j <= 34; j++) begin
            @(negedge clk);
            if (j == 2) begin
                check("b2b_second_pending", 32'(wr_ready), 32'h0);
                check("b2b_first_d0", 32'(seg), 32'hf9);
            end
            if (j == 32) check("b2b_boundary", 32'(frame_done), 32'h1);
            if (j == 33) check("b2b_first_d3_last", 32'(seg), 32'hf9);
            if (j == 34) check("b2b_second_d0", 32'(seg), 32'ha4);
        end

        // Reset at digit 2 slot 5 with a frame pending in the shadow buffer
        wait_frame(c);
        wr_data  = 16'h9999;
        wr_dp    = 4'b1111;
        wr_valid = 1'b1;
        @(posedge clk);
        #1 wr_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_pending", 32'(wr_ready), 32'h0);
        repeat (21) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_dig_sel", 32'(dig_sel), 32'h0f);
        check("mid_rst_seg", 32'(seg), 32'hff);
        check("mid_rst_wr_ready", 32'(wr_ready), 32'h1);
        check("mid_rst_frame_done", 32'(frame_done), 32'h0);
        rst = 1'b0;
        wait_frame(c);
        check("mid_rst_frame_period", c, 31);
        capture();
        check_digits(post_rst, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
